// File: rtl/br_resolve_pkg.sv
// Shared definitions for branch resolution: opcodes, funct3 codes, FSM encoding
// and the B-immediate decoder that decode and execute both use.
package br_resolve_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_IDLE,
        ST_SQUASH
    } br_state_t;

    // 13-bit signed branch offset; callers sign-extend to their datapath width.
    function automatic logic signed [12:0] b_imm(input logic [31:0] ir);
        logic unused_fields;
        unused_fields = ^{ir[24:12], ir[6:0]};
        return {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/br_resolve_if.sv
// EX-stage branch resolution bundle: instruction/operands in, redirect and stats out.
interface br_resolve_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 64
);
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [31:0]      ex_ir;
    logic [XLEN-1:0]  ex_rs1;
    logic [XLEN-1:0]  ex_rs2;
    logic             ex_pr_taken;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush;
    logic             squash_ex;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mp_cnt;

    modport master (
        output ex_valid, ex_pc, ex_ir, ex_rs1, ex_rs2, ex_pr_taken,
        input  redirect, redirect_pc, flush, squash_ex, br_cnt, mp_cnt
    );

    modport slave (
        input  ex_valid, ex_pc, ex_ir, ex_rs1, ex_rs2, ex_pr_taken,
        output redirect, redirect_pc, flush, squash_ex, br_cnt, mp_cnt
    );
endinterface

// File: rtl/br_cmp.sv
// Branch condition evaluator: decides taken for a funct3 and flags the
// two reserved funct3 codes as not-a-branch.
module br_cmp
    import br_resolve_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            legal
);

    logic signed [XLEN-1:0] rs1_s;
    logic signed [XLEN-1:0] rs2_s;

    assign rs1_s = rs1;
    assign rs2_s = rs2;

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = (rs1_s < rs2_s);
            F3_BGE:  taken = (rs1_s >= rs2_s);
            F3_BLTU: taken = (rs1 < rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/br_resolve.sv
// Execute-stage branch/JALR resolution: checks the decode prediction, issues a
// registered redirect on mismatch and squashes the wrong path for FLUSH_CYCLES.
module br_resolve
    import br_resolve_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 64
) (
    input  logic         clk,
    input  logic         rst,
    br_resolve_if.slave  bus
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    logic [6:0]             opcode_p0;
    logic [2:0]             funct3_p0;
    logic                   taken_p0;
    logic                   legal_p0;
    logic                   is_br_p0;
    logic                   is_jalr_p0;
    logic                   mispredict_p0;
    logic                   event_p0;
    logic                   idle_p0;
    logic signed [12:0]     boff_p0;
    logic signed [XLEN-1:0] boff_x_p0;
    logic signed [XLEN-1:0] joff_x_p0;
    logic [XLEN-1:0]        tgt_taken_p0;
    logic [XLEN-1:0]        tgt_seq_p0;
    logic [XLEN-1:0]        tgt_jalr_p0;
    logic [XLEN-1:0]        tgt_p0;

    br_state_t              state;
    br_state_t              state_n;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_n;
    logic                   redirect_p1;
    logic                   flush_p1;
    logic [XLEN-1:0]        redirect_pc_p1;
    logic [CNT_W-1:0]       br_cnt;
    logic [CNT_W-1:0]       mp_cnt;

    // Stage p0: combinational decode, compare and target generation
    assign opcode_p0 = bus.ex_ir[6:0];
    assign funct3_p0 = bus.ex_ir[14:12];

    br_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3 (funct3_p0),
        .rs1    (bus.ex_rs1),
        .rs2    (bus.ex_rs2),
        .taken  (taken_p0),
        .legal  (legal_p0)
    );

    assign idle_p0       = (state == ST_IDLE);
    assign is_br_p0      = bus.ex_valid && (opcode_p0 == OP_BRANCH) && legal_p0;
    assign is_jalr_p0    = bus.ex_valid && (opcode_p0 == OP_JALR) && (funct3_p0 == 3'b000);
    assign mispredict_p0 = is_br_p0 && (taken_p0 != bus.ex_pr_taken);
    assign event_p0      = idle_p0 && (mispredict_p0 || is_jalr_p0);

    assign boff_p0      = b_imm(bus.ex_ir);
    assign boff_x_p0    = {{(XLEN-13){boff_p0[12]}}, boff_p0};
    assign joff_x_p0    = {{(XLEN-12){bus.ex_ir[31]}}, bus.ex_ir[31:20]};
    assign tgt_taken_p0 = bus.ex_pc + boff_x_p0;
    assign tgt_seq_p0   = bus.ex_pc + XLEN'(4);
    assign tgt_jalr_p0  = (bus.ex_rs1 + joff_x_p0) & ~XLEN'(1);
    assign tgt_p0       = is_jalr_p0 ? tgt_jalr_p0 : (taken_p0 ? tgt_taken_p0 : tgt_seq_p0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: begin
                if (event_p0) begin
                    state_n = ST_SQUASH;
                    cnt_n   = CW'(FLUSH_CYCLES);
                end
            end
            ST_SQUASH: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Stage p1: registered redirect, squash window and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            redirect_p1    <= 1'b0;
            flush_p1       <= 1'b0;
            redirect_pc_p1 <= '0;
            br_cnt         <= '0;
            mp_cnt         <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            redirect_p1 <= event_p0;
            flush_p1    <= event_p0;
            if (event_p0) begin
                redirect_pc_p1 <= tgt_p0;
            end
            if (idle_p0 && is_br_p0) begin
                br_cnt <= br_cnt + CNT_W'(1);
            end
            if (event_p0) begin
                mp_cnt <= mp_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.redirect    = redirect_p1;
    assign bus.flush       = flush_p1;
    assign bus.redirect_pc = redirect_pc_p1;
    assign bus.squash_ex   = (state == ST_SQUASH);
    assign bus.br_cnt      = br_cnt;
    assign bus.mp_cnt      = mp_cnt;

endmodule

// File: tb/tb_br_resolve.sv
// Directed-vector bench for br_resolve with hand-computed redirect targets and counts.
module tb_br_resolve;
    import br_resolve_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    br_resolve_if #(.XLEN(64), .CNT_W(64)) bus ();

    br_resolve #(.XLEN(64), .FLUSH_CYCLES(2), .CNT_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] off);
        return {off[12], off[10:5], 5'd0, 5'd0, f3, off[4:1], off[11], OP_BRANCH};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, 5'd0, OP_JALR};
    endfunction

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ir,
                         input logic [63:0] a, input logic [63:0] b, input logic pr);
        bus.ex_valid    = v;
        bus.ex_pc       = pc;
        bus.ex_ir       = ir;
        bus.ex_rs1      = a;
        bus.ex_rs2      = b;
        bus.ex_pr_taken = pr;
    endtask

    task automatic idle();
        drive(1'b0, 64'h0, 32'h0000_0013, 64'h0, 64'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic r, input logic [63:0] rpc,
                              input logic f, input logic sq, input logic [63:0] br,
                              input logic [63:0] mp);
        check({tag, ".redirect"}, {63'd0, bus.redirect}, {63'd0, r});
        if (r) check({tag, ".redirect_pc"}, bus.redirect_pc, rpc);
        check({tag, ".flush"}, {63'd0, bus.flush}, {63'd0, f});
        check({tag, ".squash_ex"}, {63'd0, bus.squash_ex}, {63'd0, sq});
        check({tag, ".br_cnt"}, bus.br_cnt, br);
        check({tag, ".mp_cnt"}, bus.mp_cnt, mp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        step();
        step();
        expect_out("reset", 1'b0, 64'h0, 1'b0, 1'b0, 64'd0, 64'd0);
        check("reset.redirect_pc", bus.redirect_pc, 64'h0);
        rst = 1'b0;

        // BEQ taken, predicted not taken
        drive(1'b1, 64'h1000, enc_b(F3_BEQ, 13'h020), 64'd5, 64'd5, 1'b0);
        step();
        expect_out("beq_mp", 1'b1, 64'h1020, 1'b1, 1'b1, 64'd1, 64'd1);
        idle();
        step();
        expect_out("beq_sq2", 1'b0, 64'h0, 1'b0, 1'b1, 64'd1, 64'd1);
        step();
        expect_out("beq_end", 1'b0, 64'h0, 1'b0, 1'b0, 64'd1, 64'd1);

        // BNE not taken, predicted taken
        drive(1'b1, 64'h2000, enc_b(F3_BNE, 13'h040), 64'd7, 64'd7, 1'b1);
        step();
        expect_out("bne_mp", 1'b1, 64'h2004, 1'b1, 1'b1, 64'd2, 64'd2);
        idle();
        step();
        step();

        // BNE taken, predicted taken: count only
        drive(1'b1, 64'h2000, enc_b(F3_BNE, 13'h040), 64'd7, 64'd8, 1'b1);
        step();
        expect_out("bne_ok", 1'b0, 64'h0, 1'b0, 1'b0, 64'd3, 64'd2);

        // BLT signed: -1 < 1 taken
        drive(1'b1, 64'h3000, enc_b(F3_BLT, 13'h040), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        step();
        expect_out("blt", 1'b1, 64'h3040, 1'b1, 1'b1, 64'd4, 64'd3);
        idle();
        step();
        step();

        // BLTU unsigned: max < 1 false
        drive(1'b1, 64'h3000, enc_b(F3_BLTU, 13'h040), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        step();
        expect_out("bltu", 1'b0, 64'h0, 1'b0, 1'b0, 64'd5, 64'd3);

        // JALR, then a mispredicting BEQ held through the squash window
        drive(1'b1, 64'h5000, enc_jalr(12'h004), 64'h1001, 64'h0, 1'b0);
        step();
        expect_out("jalr", 1'b1, 64'h1004, 1'b1, 1'b1, 64'd5, 64'd4);
        drive(1'b1, 64'h4000, enc_b(F3_BEQ, 13'h010), 64'd1, 64'd1, 1'b0);
        step();
        expect_out("sq_ign1", 1'b0, 64'h0, 1'b0, 1'b1, 64'd5, 64'd4);
        step();
        expect_out("sq_ign2", 1'b0, 64'h0, 1'b0, 1'b0, 64'd5, 64'd4);
        step();
        expect_out("first_idle", 1'b1, 64'h4010, 1'b1, 1'b1, 64'd6, 64'd5);
        idle();
        step();
        step();

        // Backward offset wrapping below zero
        drive(1'b1, 64'h0, enc_b(F3_BEQ, 13'h1FF8), 64'd3, 64'd3, 1'b0);
        step();
        expect_out("wrap", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b1, 64'd7, 64'd6);

        // Reset mid-squash, with a qualifying event presented alongside
        rst = 1'b1;
        step();
        expect_out("rst_sq", 1'b0, 64'h0, 1'b0, 1'b0, 64'd0, 64'd0);
        step();
        expect_out("rst_prio", 1'b0, 64'h0, 1'b0, 1'b0, 64'd0, 64'd0);
        rst = 1'b0;

        // Reserved funct3 010 is not a branch
        drive(1'b1, 64'h6000, enc_b(3'b010, 13'h020), 64'd1, 64'd1, 1'b1);
        step();
        expect_out("f3_010", 1'b0, 64'h0, 1'b0, 1'b0, 64'd0, 64'd0);

        // JAL opcode is ignored
        drive(1'b1, 64'h6000, 32'h0000_006F, 64'd1, 64'd1, 1'b0);
        step();
        expect_out("jal", 1'b0, 64'h0, 1'b0, 1'b0, 64'd0, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
